// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and helpers for the SPI data FIFOs.
//   FRAME_SIZE_DEF - default data word width
//   FIFO_DEPTH_DEF - default number of word slots
//   COUNT_W        - occupancy counter width; six bits hold 0..32 with no overflow
//   ptr_width()    - pointer width for a given depth (at least one bit)
package spi_pkg;
    localparam int FRAME_SIZE_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int COUNT_W        = 6;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/spi_fifo_ram.sv
// spi_fifo_ram: simple dual-port word array, synchronous write, asynchronous read.
//   pclk  - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write word
//   raddr - read address
//   rdata - read word (combinational from raddr)
// The array has no reset; its contents are only meaningful behind the pointers.
module spi_fifo_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          pclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/spi_data_fifo.sv
// spi_data_fifo: circular word FIFO for SPI transmit/receive data.
//   pclk, aresetn          - clock and asynchronous active-low reset
//   clr_fifo               - synchronous flush, overrides reads and writes
//   wr_en, wr_data         - write request and word
//   rd_en, rd_data         - read request and word
//   full, full_next        - count == DEPTH, count == DEPTH-1
//   empty, empty_next      - count == 0, count == 1
//   overflow, underflow    - one-cycle pulses for rejected writes / reads
//   count                  - current occupancy
// Macro SPI_DATA_FIFO_FWFT_EN selects first-word-fall-through reads; when it is
// undefined rd_data is registered and updates one cycle after an accepted read.
module spi_data_fifo
    import spi_pkg::*;
#(
    parameter int CFG_FRAME_SIZE = FRAME_SIZE_DEF,
    parameter int CFG_FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                      pclk,
    input  logic                      aresetn,
    input  logic                      clr_fifo,
    input  logic                      wr_en,
    input  logic [CFG_FRAME_SIZE-1:0] wr_data,
    input  logic                      rd_en,
    output logic [CFG_FRAME_SIZE-1:0] rd_data,
    output logic                      full,
    output logic                      full_next,
    output logic                      empty,
    output logic                      empty_next,
    output logic                      overflow,
    output logic                      underflow,
    output logic [COUNT_W-1:0]        count
);
    localparam int AW = ptr_width(CFG_FIFO_DEPTH);
    localparam logic [AW-1:0]      LAST  = AW'(CFG_FIFO_DEPTH - 1);
    localparam logic [COUNT_W-1:0] DEPTH = COUNT_W'(CFG_FIFO_DEPTH);

    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CFG_FRAME_SIZE-1:0] ram_rdata;
    logic                      rd_acc, wr_acc;
    logic [COUNT_W-1:0]        count_nxt;

    // A write while full is still taken when a read frees the head slot in
    // the same cycle; a read while empty is never bypassed by the write.
    assign rd_acc    = !clr_fifo && rd_en && !empty;
    assign wr_acc    = !clr_fifo && wr_en && (!full || rd_acc);
    assign count_nxt = clr_fifo ? '0 : count + COUNT_W'(wr_acc) - COUNT_W'(rd_acc);

    spi_fifo_ram #(
        .W     (CFG_FRAME_SIZE),
        .DEPTH (CFG_FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .pclk  (pclk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            full_next  <= 1'b0;
            empty      <= 1'b1;
            empty_next <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= clr_fifo ? '0 : wr_acc ? ((wr_ptr == LAST) ? '0 : wr_ptr + 1'b1) : wr_ptr;
            rd_ptr     <= clr_fifo ? '0 : rd_acc ? ((rd_ptr == LAST) ? '0 : rd_ptr + 1'b1) : rd_ptr;
            count      <= count_nxt;
            full       <= count_nxt == DEPTH;
            full_next  <= count_nxt == DEPTH - 1'b1;
            empty      <= count_nxt == '0;
            empty_next <= count_nxt == COUNT_W'(1);
            overflow   <= !clr_fifo && wr_en && full && !rd_en;
            underflow  <= !clr_fifo && rd_en && empty;
        end
    end

`ifdef SPI_DATA_FIFO_FWFT_EN
    // Head word is visible as soon as it exists; zero while empty.
    assign rd_data = empty ? '0 : ram_rdata;
`else
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) rd_data <= '0;
        else if (rd_acc) rd_data <= ram_rdata;
    end
`endif
endmodule

// File: tb/tb_spi_data_fifo.sv
// tb_spi_data_fifo: directed table-driven bench for spi_data_fifo (registered-read build).
module tb_spi_data_fifo;
    logic       pclk = 1'b0;
    logic       aresetn = 1'b0;
    always #5 pclk = ~pclk;

    logic       clr_fifo = 0, wr_en = 0, rd_en = 0;
    logic [7:0] wr_data = '0, rd_data;
    logic       full, full_next, empty, empty_next, overflow, underflow;
    logic [5:0] count;

    logic       clr3 = 0, wr3 = 0, rd3 = 0;
    logic [7:0] wd3 = '0, rdd3;
    logic       f3, fn3, e3, en3, o3, u3;
    logic [5:0] c3;

    spi_data_fifo #(.CFG_FRAME_SIZE(8), .CFG_FIFO_DEPTH(4)) u_dut (
        .pclk(pclk), .aresetn(aresetn), .clr_fifo(clr_fifo), .wr_en(wr_en),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .full(full),
        .full_next(full_next), .empty(empty), .empty_next(empty_next),
        .overflow(overflow), .underflow(underflow), .count(count)
    );

    spi_data_fifo #(.CFG_FRAME_SIZE(8), .CFG_FIFO_DEPTH(3)) u_dut3 (
        .pclk(pclk), .aresetn(aresetn), .clr_fifo(clr3), .wr_en(wr3),
        .wr_data(wd3), .rd_en(rd3), .rd_data(rdd3), .full(f3),
        .full_next(fn3), .empty(e3), .empty_next(en3),
        .overflow(o3), .underflow(u3), .count(c3)
    );

    int checks = 0, failures = 0;

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic [19:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [19:0] pack(input int cnt, input logic f, fn, e, en, o, u, input logic [7:0] d);
        return {6'(cnt), f, fn, e, en, o, u, d};
    endfunction

    function automatic logic [19:0] obs4();
        return {count, full, full_next, empty, empty_next, overflow, underflow, rd_data};
    endfunction

    function automatic logic [19:0] obs3();
        return {c3, f3, fn3, e3, en3, o3, u3, rdd3};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={cnt=%0d f=%b fn=%b e=%b en=%b ov=%b un=%b rd=%h} expected={cnt=%0d f=%b fn=%b e=%b en=%b ov=%b un=%b rd=%h}",
                     name, act[19:14], act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[19:14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic add(input logic wr, rd, clr, input logic [7:0] din, input int cnt,
                       input logic f, fn, e, en, o, u, input logic [7:0] d);
        vq.push_back('{wr, rd, clr, din, pack(cnt, f, fn, e, en, o, u, d)});
    endtask

    task automatic step4(input logic wr, rd, clr, input logic [7:0] din);
        wr_en = wr; rd_en = rd; clr_fifo = clr; wr_data = din;
        @(posedge pclk); #1;
        wr_en = 0; rd_en = 0; clr_fifo = 0;
    endtask

    task automatic step3(input logic wr, rd, input logic [7:0] din);
        wr3 = wr; rd3 = rd; wd3 = din;
        @(posedge pclk); #1;
        wr3 = 0; rd3 = 0;
    endtask

    initial begin
        //   wr rd clr din    cnt f  fn e  en ov un rd_data
        add(1, 0, 0, 8'hA1, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        add(1, 0, 0, 8'hB2, 2, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 8'hC3, 3, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 8'hD4, 4, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 8'hEE, 4, 1, 0, 0, 0, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 4, 1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 1, 0, 8'h00, 3, 0, 1, 0, 0, 0, 0, 8'hA1);
        add(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'hB2);
        add(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'hC3);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'hD4);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'hD4);
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'hD4);
        add(1, 1, 0, 8'h5A, 1, 0, 0, 0, 1, 0, 1, 8'hD4);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h5A);
        add(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 0, 0, 8'h5A);
        add(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 8'h5A);
        add(1, 0, 0, 8'h03, 3, 0, 1, 0, 0, 0, 0, 8'h5A);
        add(1, 0, 1, 8'h77, 0, 0, 0, 1, 0, 0, 0, 8'h5A);
        add(1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h5A);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h11);
        add(1, 0, 0, 8'h21, 1, 0, 0, 0, 1, 0, 0, 8'h11);
        add(1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 8'h11);
        add(1, 0, 0, 8'h23, 3, 0, 1, 0, 0, 0, 0, 8'h11);
        add(1, 0, 0, 8'h24, 4, 1, 0, 0, 0, 0, 0, 8'h11);
        add(1, 1, 0, 8'h25, 4, 1, 0, 0, 0, 0, 0, 8'h21);
        add(0, 1, 0, 8'h00, 3, 0, 1, 0, 0, 0, 0, 8'h22);
        add(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'h23);
        add(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h24);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h25);
        add(0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h25);

        repeat (2) @(posedge pclk);
        #1;
        check("reset4", obs4(), pack(0, 0, 0, 1, 0, 0, 0, 8'h00));
        check("reset3", obs3(), pack(0, 0, 0, 1, 0, 0, 0, 8'h00));
        aresetn = 1;

        foreach (vq[i]) begin
            step4(vq[i].wr, vq[i].rd, vq[i].clr, vq[i].din);
            check($sformatf("vec%0d", i), obs4(), vq[i].exp);
        end

        // Asynchronous reset in mid-operation discards stored words.
        step4(1, 0, 0, 8'h41);
        step4(1, 0, 0, 8'h42);
        check("pre_rst", obs4(), pack(2, 0, 0, 0, 0, 0, 0, 8'h25));
        #2 aresetn = 0;
        #1 check("async_rst", obs4(), pack(0, 0, 0, 1, 0, 0, 0, 8'h00));
        @(posedge pclk); #1 aresetn = 1;
        step4(1, 0, 0, 8'h33);
        check("post_rst_wr", obs4(), pack(1, 0, 0, 0, 1, 0, 0, 8'h00));
        step4(0, 1, 0, 8'h00);
        check("post_rst_rd", obs4(), pack(0, 0, 0, 1, 0, 0, 0, 8'h33));

        // DEPTH=3: fill, drain, then streaming pairs across pointer wrap.
        step3(1, 0, 8'hC0);
        check("d3_fill1", obs3(), pack(1, 0, 0, 0, 1, 0, 0, 8'h00));
        step3(1, 0, 8'hC1);
        check("d3_fill2", obs3(), pack(2, 0, 1, 0, 0, 0, 0, 8'h00));
        step3(1, 0, 8'hC2);
        check("d3_fill3", obs3(), pack(3, 1, 0, 0, 0, 0, 0, 8'h00));
        step3(1, 0, 8'hCF);
        check("d3_ovf", obs3(), pack(3, 1, 0, 0, 0, 1, 0, 8'h00));
        for (int k = 0; k < 3; k++) begin
            step3(0, 1, 8'h00);
            check($sformatf("d3_drain%0d", k), obs3(),
                  pack(2 - k, 0, k == 0, k == 2, k == 1, 0, 0, 8'hC0 + 8'(k)));
        end
        step3(1, 0, 8'h00);
        check("d3_pair0", obs3(), pack(1, 0, 0, 0, 1, 0, 0, 8'hC2));
        for (int k = 1; k < 10; k++) begin
            step3(1, 1, 8'(k));
            check($sformatf("d3_pair%0d", k), obs3(), pack(1, 0, 0, 0, 1, 0, 0, 8'(k - 1)));
        end
        step3(0, 1, 8'h00);
        check("d3_last", obs3(), pack(0, 0, 0, 1, 0, 0, 0, 8'h09));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
